stream_arb4: RTL and testbench

Four-source round-robin stream arbiter with a registered output stage. It picks one of four valid/ready input streams per cycle, steers that stream's data through the team's 4:1 mux using a 2-bit select, and registers the chosen beat with its source index. It sits directly upstream of any consumer that needs a single merged stream, for example the shared engine input port.

---
 rtl/stream_arb4.sv | 168 ++++++++++++++++
 tb/tb_stream_arb4.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb4.sv
// stream_arb4: four-source round-robin stream arbiter with a registered output.
//
// One valid/ready source is chosen per cycle by a rotating priority pointer.
// Its payload is steered through a 4:1 mux and captured, together with the
// source index, in a single output register that can be drained and refilled
// on the same edge.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid[3:0]        per-source valid (bit i belongs to in_data{i})
//   in_ready[3:0]        per-source ready, at most one bit high
//   in_data0..in_data3   source payloads, WIDTH bits each
//   out_valid/out_ready  output handshake
//   out_data             registered payload
//   out_src              index of the source that produced out_data
//
// Optional feature (macro STREAM_ARB_LOCK_EN): packet lock. Adds in_last[3:0]
// and out_last. A granted source keeps the grant until its beat with
// in_last=1 is accepted; the pointer only advances on that last beat.
module stream_arb4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
`ifdef STREAM_ARB_LOCK_EN
  input  logic [3:0]       in_last,
  output logic             out_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             load;
  logic             take;
  logic             any_req;
  logic [1:0]       grant;
  logic             rr_any;
  logic [1:0]       rr_grant;
  logic [1:0]       rr_idx;
  logic [WIDTH-1:0] mux_out;

`ifdef STREAM_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [1:0]       lock_src_q, lock_src_d;
  logic             out_last_q, out_last_d;
`endif

  // Round-robin search: first valid source starting at ptr and wrapping.
  always_comb begin
    rr_grant = '0;
    rr_any   = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rr_idx = ptr_q + 2'(k);
      if (!rr_any && in_valid[rr_idx]) begin
        rr_grant = rr_idx;
        rr_any   = 1'b1;
      end
    end
  end

`ifdef STREAM_ARB_LOCK_EN
  // While locked, only the owning source may transfer; its valid alone
  // decides whether a beat is available.
  assign grant   = lock_q ? lock_src_q : rr_grant;
  assign any_req = lock_q ? in_valid[lock_src_q] : rr_any;
`else
  assign grant   = rr_grant;
  assign any_req = rr_any;
`endif

  assign load = !out_valid_q || out_ready;
  assign take = load && any_req;

  always_comb begin
    in_ready = '0;
    if (rst_n && take) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    case (grant)
      2'd0:    mux_out = in_data0;
      2'd1:    mux_out = in_data1;
      2'd2:    mux_out = in_data2;
      default: mux_out = in_data3;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
`ifdef STREAM_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_src_d  = lock_src_q;
    out_last_d  = out_last_q;
`endif
    if (load) begin
      if (any_req) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_out;
        out_src_d   = grant;
`ifdef STREAM_ARB_LOCK_EN
        out_last_d  = in_last[grant];
        if (in_last[grant]) begin
          lock_d = 1'b0;
          ptr_d  = grant + 2'd1;
        end else begin
          lock_d     = 1'b1;
          lock_src_d = grant;
        end
`else
        ptr_d       = grant + 2'd1;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
`ifdef STREAM_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_src_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_src_q  <= lock_src_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
`ifdef STREAM_ARB_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_arb4.sv
// Self-checking bench for stream_arb4: directed scenarios plus a randomized
// run, all compared against a behavioural model of the arbiter.
module tb_stream_arb4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] din [4];
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_src;
`ifdef STREAM_ARB_LOCK_EN
  logic [3:0] in_last;
  logic       out_last;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit       m_valid    = 0;
  bit [7:0] m_data     = 0;
  int       m_src      = 0;
  int       m_ptr      = 0;
  bit       m_lock     = 0;
  int       m_lock_src = 0;
  bit       m_last     = 0;

  stream_arb4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (din[0]),
    .in_data1  (din[1]),
    .in_data2  (din[2]),
    .in_data3  (din[3]),
`ifdef STREAM_ARB_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  // Source that wins this cycle, or -1 when nobody can transfer.
  function automatic int m_grant();
    if (m_lock) return in_valid[m_lock_src] ? m_lock_src : -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g;
    g = m_grant();
    if (!rst_n) return 4'b0000;
    if ((!m_valid || out_ready) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  // Advance one clock edge and the model with it; leaves time at edge+1.
  task automatic tick();
    int g;
    bit ld;
    g  = m_grant();
    ld = !m_valid || out_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
      m_lock = 0; m_lock_src = 0; m_last = 0;
    end else if (ld) begin
      if (g < 0) begin
        m_valid = 0;
      end else begin
        m_valid = 1;
        m_data  = din[g];
        m_src   = g;
`ifdef STREAM_ARB_LOCK_EN
        m_last  = in_last[g];
        if (in_last[g]) begin
          m_lock = 0;
          m_ptr  = (g + 1) % 4;
        end else begin
          m_lock     = 1;
          m_lock_src = g;
        end
`else
        m_ptr   = (g + 1) % 4;
`endif
      end
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 4'b1111; out_ready = 1; rand_data();
    tick(); tick();
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      failures++; $display("FAIL reset_out_data: got %h expected 00", out_data);
    end
    checks++;
    if (out_src !== 2'd0) begin
      failures++; $display("FAIL reset_out_src: got %0d expected 0", out_src);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1; in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        failures++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", i, in_ready, m_ready());
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(i % 4)) begin
        failures++;
        $display("FAIL rr_beat[%0d]: got valid=%b src=%0d expected valid=1 src=%0d", i, out_valid, out_src, i % 4);
      end
      checks++;
      if (out_data !== m_data) begin
        failures++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_data, m_data);
      end
    end
  endtask

  task automatic test_single_source();
    in_valid = 4'b0100; out_ready = 1; rand_data(); din[2] = 8'hA5;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL single_in_ready: got %b expected 0100", in_ready);
    end
    tick();
    checks++;
    if (out_data !== 8'hA5 || out_src !== 2'd2) begin
      failures++; $display("FAIL single_beat: got data=%h src=%0d expected data=a5 src=2", out_data, out_src);
    end
    // Pointer now 3: with everyone requesting, source 3 must win.
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++; $display("FAIL single_ptr_next: got %b expected 1000", in_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] saved_data;
    logic [1:0] saved_src;
    in_valid = 4'b1010; out_ready = 1; rand_data();
    tick();
    saved_data = out_data; saved_src = out_src;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd1) begin
      failures++; $display("FAIL bp_fill: got valid=%b src=%0d expected valid=1 src=1", out_valid, out_src);
    end
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== saved_data || out_src !== saved_src) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d expected v=1 d=%h s=%0d", i, out_valid, out_data, out_src, saved_data, saved_src);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++; $display("FAIL bp_release_ready: got %b expected 1000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== din[3]) begin
      failures++;
      $display("FAIL bp_release_beat: got v=%b s=%0d d=%h expected v=1 s=3 d=%h", out_valid, out_src, out_data, din[3]);
    end
  endtask

  task automatic test_wrap();
    in_valid = 4'b0100; out_ready = 1; rand_data();
    tick();
    in_valid = 4'b1001;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++; $display("FAIL wrap_first_ready: got %b expected 1000", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd3) begin
      failures++; $display("FAIL wrap_first_src: got %0d expected 3", out_src);
    end
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++; $display("FAIL wrap_second_ready: got %b expected 0001", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd0) begin
      failures++; $display("FAIL wrap_second_src: got %0d expected 0", out_src);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b0010; out_ready = 1; rand_data();
    tick();
    rst_n = 0;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++; $display("FAIL midrst_in_ready: got %b expected 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
      failures++;
      $display("FAIL midrst_state: got v=%b d=%h s=%0d expected v=0 d=00 s=0", out_valid, out_data, out_src);
    end
    rst_n = 1; in_valid = 4'b1111;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      failures++; $display("FAIL midrst_restart: got v=%b s=%0d expected v=1 s=0", out_valid, out_src);
    end
  endtask

`ifdef STREAM_ARB_LOCK_EN
  task automatic test_lock();
    rst_n = 0; in_last = 4'b0000; in_valid = 4'b0000; out_ready = 1;
    tick();
    rst_n = 1; in_valid = 4'b0110; rand_data();
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 4'b0010 : 4'b0000;
      din[1]  = 8'(8'h10 + b);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        failures++; $display("FAIL lock_ready[%0d]: got %b expected 0010", b, in_ready);
      end
      tick();
      checks++;
      if (out_src !== 2'd1 || out_data !== 8'(8'h10 + b) || out_last !== (b == 2)) begin
        failures++;
        $display("FAIL lock_beat[%0d]: got s=%0d d=%h l=%b expected s=1 d=%h l=%b", b, out_src, out_data, out_last, 8'(8'h10 + b), (b == 2));
      end
    end
    in_last = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL lock_release_ready: got %b expected 0100", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd2) begin
      failures++; $display("FAIL lock_release_src: got %0d expected 2", out_src);
    end
    in_last = 4'b1111;
    tick();
  endtask
`endif

  task automatic test_random();
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_ARB_LOCK_EN
      in_last   = 4'($urandom);
`endif
      rand_data();
      #1;
      checks++;
      if (in_ready !== m_ready() || !$onehot0(in_ready)) begin
        failures++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, m_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== 2'(m_src)) begin
        failures++;
        $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d", i, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
`ifdef STREAM_ARB_LOCK_EN
      checks++;
      if (out_last !== m_last) begin
        failures++; $display("FAIL rand_out_last[%0d]: got %b expected %b", i, out_last, m_last);
      end
`endif
    end
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_valid = 4'b0000; out_ready = 1;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
`ifdef STREAM_ARB_LOCK_EN
    in_last = 4'b1111;
`endif
    #1;
    test_reset();
    test_round_robin();
    test_single_source();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef STREAM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
